// File: rtl/computie_bus_pkg.sv
// Shared definitions for the computie bus recorder and dumper: record layout
// helpers and the bus-cycle detector states.
package computie_bus_pkg;

  localparam int unsigned BUS_BITWIDTH = 32;
  localparam int unsigned BUS_MODWIDTH = 1;

  // Record layout for the standard 32-bit build: {mod, addr, data}
  localparam int unsigned REC_DATA_LSB = 0;
  localparam int unsigned REC_ADDR_LSB = BUS_BITWIDTH;
  localparam int unsigned REC_MOD_LSB  = 2 * BUS_BITWIDTH;

  function automatic int unsigned rec_addr_lsb(input int unsigned bitwidth);
    return bitwidth;
  endfunction

  function automatic int unsigned rec_mod_lsb(input int unsigned bitwidth);
    return 2 * bitwidth;
  endfunction

  function automatic int unsigned rec_width(input int unsigned bitwidth,
                                            input int unsigned modwidth);
    return 2 * bitwidth + modwidth;
  endfunction

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    CAPTURED = 2'd2
  } det_state_e;

endpackage

// File: rtl/computie_bus_recorder_if.sv
// Computie bus snoop signals; the master drives the bus, the recorder only listens.
interface computie_bus_recorder_if #(
  parameter int unsigned BITWIDTH = 32
);
  logic                bus_as_n;
  logic                bus_dtack_n;
  logic                bus_read;
  logic [BITWIDTH-1:0] bus_addr;
  logic [BITWIDTH-1:0] bus_data;

  modport master (
    output bus_as_n, bus_dtack_n, bus_read, bus_addr, bus_data
  );

  modport slave (
    input bus_as_n, bus_dtack_n, bus_read, bus_addr, bus_data
  );
endinterface

// File: rtl/computie_bus_record_ram.sv
// Simple dual-port record RAM: one synchronous write port, one registered read
// port, no reset so it maps onto block RAM.
module computie_bus_record_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 65
) (
  input  logic                     comm_clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge comm_clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/computie_bus_recorder.sv
// Passive computie bus snooper: records completed bus cycles into a circular
// buffer and serves them oldest-first to the dumper.
module computie_bus_recorder
  import computie_bus_pkg::*;
#(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned MODWIDTH = 1,
  parameter int unsigned DEPTH    = 512
) (
  input  logic                                     comm_clock,
  input  logic                                     comm_reset_n,
  computie_bus_recorder_if.slave                   bus,
  input  logic                                     record_enable,
  input  logic                                     record_clear,
  input  logic                                     dump_active,
  input  logic [$clog2(DEPTH):0]                   record_request,
  output logic [$clog2(DEPTH):0]                   record_max,
  output logic                                     record_empty,
  output logic [rec_width(BITWIDTH, MODWIDTH)-1:0] record_out,
  output logic                                     overflow
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned IDX_W    = PTR_W + 1;
  localparam int unsigned REC_W    = rec_width(BITWIDTH, MODWIDTH);
  localparam int unsigned ADDR_LSB = rec_addr_lsb(BITWIDTH);
  localparam int unsigned MOD_LSB  = rec_mod_lsb(BITWIDTH);

  logic [1:0]       as_sync;
  logic [1:0]       dtack_sync;
  logic             as_s;
  logic             dtack_s;
  det_state_e       state;
  det_state_e       state_nxt;
  logic             snap_c;
  logic [REC_W-1:0] snap_rec;
  logic             wr_valid;
  logic [REC_W-1:0] wr_rec;
  logic             commit_c;
  logic [PTR_W-1:0] wr_ptr;
  logic [IDX_W-1:0] count;
  logic [PTR_W-1:0] oldest;
  logic [PTR_W-1:0] rd_addr;
  logic [REC_W-1:0] rd_data;
  logic             unused_req_msb;

  // Strobes are asynchronous to comm_clock; idle-high synchronizers
  always_ff @(posedge comm_clock or negedge comm_reset_n) begin
    if (!comm_reset_n) begin
      as_sync    <= 2'b11;
      dtack_sync <= 2'b11;
    end else begin
      as_sync    <= {as_sync[0], bus.bus_as_n};
      dtack_sync <= {dtack_sync[0], bus.bus_dtack_n};
    end
  end

  assign as_s    = as_sync[1];
  assign dtack_s = dtack_sync[1];

  always_ff @(posedge comm_clock or negedge comm_reset_n) begin
    if (!comm_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Cycle detector: one snapshot per bus cycle, on the first synchronized dtack
  always_comb begin
    state_nxt = state;
    snap_c    = 1'b0;
    case (state)
      IDLE: begin
        if (!as_s) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (as_s) begin
          state_nxt = IDLE;
        end else if (!dtack_s) begin
          state_nxt = CAPTURED;
          snap_c    = 1'b1;
        end
      end
      CAPTURED: begin
        if (as_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data/direction are held stable by the bus, so they are sampled raw
  always_comb begin
    snap_rec                          = '0;
    snap_rec[MOD_LSB]                 = bus.bus_read;
    snap_rec[ADDR_LSB +: BITWIDTH]    = bus.bus_addr;
    snap_rec[REC_DATA_LSB +: BITWIDTH] = bus.bus_data;
  end

  always_ff @(posedge comm_clock or negedge comm_reset_n) begin
    if (!comm_reset_n) begin
      wr_valid <= 1'b0;
      wr_rec   <= '0;
    end else begin
      wr_valid <= snap_c && record_enable && !dump_active;
      if (snap_c) wr_rec <= snap_rec;
    end
  end

  assign commit_c = wr_valid && !record_clear;

  // Circular buffer bookkeeping; clear wins over a same-cycle commit
  always_ff @(posedge comm_clock or negedge comm_reset_n) begin
    if (!comm_reset_n) begin
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (record_clear) begin
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (wr_valid) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (count == IDX_W'(DEPTH)) begin
        overflow <= 1'b1;
      end else begin
        count <= count + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge comm_clock or negedge comm_reset_n) begin
    if (!comm_reset_n) begin
      record_max   <= '0;
      record_empty <= 1'b1;
    end else begin
      record_max   <= (count == '0) ? '0 : count - IDX_W'(1);
      record_empty <= (count == '0);
    end
  end

  assign oldest         = wr_ptr - PTR_W'(count);
  assign rd_addr        = oldest + record_request[PTR_W-1:0];
  assign unused_req_msb = record_request[IDX_W-1];

  computie_bus_record_ram #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_ram (
    .comm_clock (comm_clock),
    .wr_en      (commit_c),
    .wr_addr    (wr_ptr),
    .wr_data    (wr_rec),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  // Gate of two registered values; RAM contents are meaningless while empty
  assign record_out = record_empty ? '0 : rd_data;

endmodule

// File: doc/computie_bus_recorder.md
# computie_bus_recorder

Passive snooper for the computie bus that sits directly upstream of the bus dumper. It captures each completed bus cycle (direction, address, data) into a circular record buffer, freezes capture while a dump is in progress, and serves stored records to the dumper by oldest-first index with one-cycle read latency.

## Interface
- BITWIDTH, 32: bus address and data width; multiple of 4.
- MODWIDTH, 1: modifier bits stored above the address; bit 0 is direction, 1 = read.
- DEPTH, 512: record count; power of two, at least 4.

- comm_clock  in  1  sole clock; all logic on the rising edge.
- comm_reset_n  in  1  asynchronous, active-low reset.
- bus_as_n  in  1  address strobe, asynchronous to comm_clock.
- bus_dtack_n  in  1  data acknowledge, asynchronous to comm_clock.
- bus_read  in  1  direction, 1 = read.
- bus_addr  in  BITWIDTH  bus address.
- bus_data  in  BITWIDTH  bus data.
- record_enable  in  1  level; capture allowed while high.
- record_clear  in  1  one-cycle pulse; empties the buffer.
- dump_active  in  1  level; high while the dumper runs; capture frozen.
- record_request  in  $clog2(DEPTH)+1  record index; 0 = oldest.
- record_max  out  $clog2(DEPTH)+1  index of newest record (count−1); 0 when empty.
- record_empty  out  1  no records stored.
- record_out  out  BITWIDTH*2+MODWIDTH  requested record: {mod, addr, data}.
- overflow  out  1  sticky; at least one record has been overwritten since the last clear.

## Operation
- Strobes pass through 2-flop synchronizers: as_s, dtack_s.
- Cycle detector FSM:
  - IDLE → ACTIVE when as_s = 0.
  - ACTIVE → CAPTURED on the first cycle with as_s = 0 and dtack_s = 0. That cycle snapshots bus_read, bus_addr and bus_data into the write stage.
  - CAPTURED → IDLE when as_s = 1.
  - ACTIVE → IDLE when as_s = 1 with no dtack; nothing is recorded.
- A snapshot commits only if record_enable = 1 and dump_active = 0 on the snapshot cycle. A suppressed cycle is lost; there is no replay.
- Commit:
  - Write at wr_ptr, then wr_ptr = wr_ptr + 1 modulo DEPTH.
  - count saturates at DEPTH.
  - When count = DEPTH, the commit overwrites the oldest record and sets overflow.
- Oldest index = wr_ptr − count, modulo DEPTH.
- Read address = (oldest + record_request[$clog2(DEPTH)−1:0]) modulo DEPTH. Requests ≥ count return undefined data; the dumper never issues them.
- record_max = count − 1 when count > 0, else 0. record_empty = (count == 0).
- record_out reads 0 whenever record_empty = 1.
- record_clear sets wr_ptr, count and overflow to 0. Clear beats a same-cycle commit, and the commit is dropped.
- Record layout: bits [BITWIDTH*2+MODWIDTH−1 : BITWIDTH*2] = mod (bit BITWIDTH*2 = read); [BITWIDTH*2−1 : BITWIDTH] = address; [BITWIDTH−1 : 0] = data.

## Timing
- Reset values: record_max = 0, record_empty = 1, record_out = 0, overflow = 0, FSM = IDLE, wr_ptr = 0, count = 0, synchronizers = 1. RAM contents are not reset.
- Capture latency:
  - dtack low at the pin → snapshot 2 cycles later (synchronizer).
  - Snapshot → RAM write and count update on the next cycle.
  - record_max and record_empty are valid the cycle after the count update.
- bus_addr, bus_data and bus_read must be stable from dtack assertion until as deassertion. They are sampled unsynchronized on the snapshot cycle.
- Read latency: record_out is registered and reflects record_request from the previous cycle. Dumper handshakes take at least 2 cycles, so this is sufficient.
- dump_active rising mid-cycle: a snapshot already in the write stage still commits, and later snapshots are suppressed. The buffer contents are therefore stable one cycle after dump_active rises.
- Reset asserted mid-cycle: everything returns to reset values at once. A partial cycle is never recorded.

## Structure
- Package computie_bus_pkg holds:
  - record field offsets (REC_DATA_LSB, REC_ADDR_LSB, REC_MOD_LSB);
  - the record width function;
  - the detector state constants (IDLE, ACTIVE, CAPTURED), shared with the dumper.
- Sub-module computie_bus_record_ram: simple dual-port RAM, DEPTH × record width. One synchronous write port, one registered read port, no reset, inferable as block RAM.

## Test plan
Bench parameters: BITWIDTH = 32, DEPTH = 8.
- Reset, no bus activity → record_empty = 1, record_max = 0, record_out = 0.
- Read cycle (addr 0x00001000, data 0xDEADBEEF, read = 1) with record_enable = 1 → record_max = 0, record_empty = 0. Request 0 returns {1, 0x00001000, 0xDEADBEEF} one cycle later.
- 10 write cycles (addr = n, data = n·0x11) → record_max = 7 and overflow = 1. Request 0 → addr 2, request 7 → addr 9.
- dump_active = 1 during 3 completed cycles → count unchanged. After dump_active falls, the next cycle is recorded.
- as_n asserted then released without dtack → no record.
- record_clear pulsed in the same cycle as a commit → count = 0 and overflow = 0. Reset asserted mid-cycle → reset values immediately.
